// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: producer channels plus merged UART transmit port
interface uart_tx_arbiter_if #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int CH_W = $clog2(NUM_CH);
  logic [NUM_CH*DATA_WIDTH-1:0] ch_tx_data;
  logic [NUM_CH-1:0]            ch_tx_valid;
  logic [NUM_CH-1:0]            ch_tx_ready;
  logic [NUM_CH-1:0]            ch_overflow;
  logic [NUM_CH-1:0]            ovf_clear;
  logic [DATA_WIDTH-1:0]        uart_tx_data;
  logic [CH_W-1:0]              uart_tx_ch;
  logic                         uart_tx_valid;
  logic                         uart_tx_ready;
  modport master (
    output ch_tx_data, ch_tx_valid, ovf_clear, uart_tx_ready,
    input  ch_tx_ready, ch_overflow, uart_tx_data, uart_tx_ch, uart_tx_valid
  );
  modport slave (
    input  ch_tx_data, ch_tx_valid, ovf_clear, uart_tx_ready,
    output ch_tx_ready, ch_overflow, uart_tx_data, uart_tx_ch, uart_tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: per-channel FIFOs merged round-robin onto one tagged UART transmit port
module uart_tx_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  typedef enum logic {IDLE, HOLD} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q [NUM_CH];
  logic [CW-1:0]         cnt_d [NUM_CH];
  logic [AW-1:0]         wp_q [NUM_CH];
  logic [AW-1:0]         wp_d [NUM_CH];
  logic [AW-1:0]         rp_q [NUM_CH];
  logic [AW-1:0]         rp_d [NUM_CH];
  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]       ch_q, ch_d, ptr_q, ptr_d, gnt;
  logic [NUM_CH-1:0]     ovf_q, ovf_d, full, push, pop;
  logic                  adv, gnt_v, take;
  always_comb begin
    adv   = state_q == IDLE || bus.uart_tx_ready;
    gnt_v = 1'b0;
    gnt   = '0;
    // Scan downward so the nearest non-empty channel after the pointer wins
    for (int k = NUM_CH; k >= 1; k--)
      if (cnt_q[(int'(ptr_q) + k) % NUM_CH] != '0) begin
        gnt_v = 1'b1;
        gnt   = CH_W'((int'(ptr_q) + k) % NUM_CH);
      end
    take = adv && gnt_v;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i]  = cnt_q[i] == CW'(FIFO_DEPTH);
      push[i]  = bus.ch_tx_valid[i] && !full[i];
      pop[i]   = take && gnt == CH_W'(i);
      cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      wp_d[i]  = wp_q[i] + AW'(push[i]);
      rp_d[i]  = rp_q[i] + AW'(pop[i]);
    end
    ovf_d   = (ovf_q & ~bus.ovf_clear) | (bus.ch_tx_valid & full);
    data_d  = take ? mem_q[gnt][rp_q[gnt]] : data_q;
    ch_d    = take ? gnt : ch_q;
    ptr_d   = take ? gnt : ptr_q;
    state_d = take ? HOLD : adv ? IDLE : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
      ovf_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        wp_q[i]  <= '0;
        rp_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        wp_q[i]  <= wp_d[i];
        rp_q[i]  <= rp_d[i];
        if (push[i]) mem_q[i][wp_q[i]] <= bus.ch_tx_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
  assign bus.ch_tx_ready   = ~full;
  assign bus.ch_overflow   = ovf_q;
  assign bus.uart_tx_data  = data_q;
  assign bus.uart_tx_ch    = ch_q;
  assign bus.uart_tx_valid = state_q == HOLD;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors with hand-computed expectations for uart_tx_arbiter
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  uart_tx_arbiter_if #(.NUM_CH(4), .DATA_WIDTH(8)) bus ();
  uart_tx_arbiter #(.NUM_CH(4), .DATA_WIDTH(8), .FIFO_DEPTH(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int c, input logic [7:0] v);
    bus.ch_tx_data[c*8 +: 8] = v;
    bus.ch_tx_valid = 4'b0001 << c;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask
  task automatic check_out(input string tag, input logic v, input logic [1:0] c, input logic [7:0] d);
    check({tag, "_valid"}, 32'(bus.uart_tx_valid), 32'(v));
    if (v) begin
      check({tag, "_ch"}, 32'(bus.uart_tx_ch), 32'(c));
      check({tag, "_data"}, 32'(bus.uart_tx_data), 32'(d));
    end
  endtask
  initial begin
    bus.ch_tx_data    = '0;
    bus.ch_tx_valid   = '0;
    bus.ovf_clear     = '0;
    bus.uart_tx_ready = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(bus.uart_tx_valid), 0);
    check("rst_data", 32'(bus.uart_tx_data), 0);
    check("rst_ch", 32'(bus.uart_tx_ch), 0);
    check("rst_ready", 32'(bus.ch_tx_ready), 32'hF);
    check("rst_ovf", 32'(bus.ch_overflow), 0);
    reset = 1'b1;
    // single byte: visible after the second edge, for one cycle
    bus.uart_tx_ready = 1'b1;
    put(2, 8'hA5);
    tick();
    bus.ch_tx_valid = '0;
    check_out("t1_e0", 1'b0, 2'd0, 8'h00);
    tick();
    check_out("t1_e1", 1'b1, 2'd2, 8'hA5);
    tick();
    check_out("t1_e2", 1'b0, 2'd0, 8'h00);
    check("t1_ovf", 32'(bus.ch_overflow), 0);
    // round robin over 3 preloaded bytes per channel
    bus.uart_tx_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) bus.ch_tx_data[c*8 +: 8] = 8'(16 * c + k);
      bus.ch_tx_valid = 4'hF;
      tick();
    end
    bus.ch_tx_valid = '0;
    bus.uart_tx_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      check_out($sformatf("t2_%0d", j), 1'b1, 2'(j % 4), 8'(16 * (j % 4) + j / 4));
      tick();
    end
    check_out("t2_end", 1'b0, 2'd0, 8'h00);
    // backpressure holds the output stable
    bus.uart_tx_ready = 1'b0;
    put(1, 8'h3C);
    tick();
    bus.ch_tx_valid = '0;
    tick();
    for (int j = 0; j < 5; j++) begin
      check_out($sformatf("t3_hold%0d", j), 1'b1, 2'd1, 8'h3C);
      tick();
    end
    bus.uart_tx_ready = 1'b1;
    check_out("t3_last", 1'b1, 2'd1, 8'h3C);
    tick();
    check_out("t3_done", 1'b0, 2'd0, 8'h00);
    // overflow: ch0 byte occupies the output so ch1 FIFO fills with exactly 8
    bus.uart_tx_ready = 1'b0;
    put(0, 8'h77);
    tick();
    bus.ch_tx_valid = '0;
    tick();
    for (int j = 1; j <= 10; j++) begin
      put(1, 8'(j));
      tick();
      check($sformatf("t4_rdy%0d", j), 32'(bus.ch_tx_ready[1]), 32'(j < 8));
      if (j == 8) check("t4_ovf_pre", 32'(bus.ch_overflow), 0);
    end
    check("t4_ovf", 32'(bus.ch_overflow), 32'h2);
    bus.ovf_clear = 4'b0010;
    tick();
    check("t4_set_wins", 32'(bus.ch_overflow), 32'h2);
    bus.ch_tx_valid = '0;
    tick();
    bus.ovf_clear = '0;
    check("t4_cleared", 32'(bus.ch_overflow), 0);
    bus.uart_tx_ready = 1'b1;
    check_out("t4_d0", 1'b1, 2'd0, 8'h77);
    tick();
    for (int j = 1; j <= 8; j++) begin
      check_out($sformatf("t4_d%0d", j), 1'b1, 2'd1, 8'(j));
      tick();
    end
    check_out("t4_end", 1'b0, 2'd0, 8'h00);
    // reset mid-operation discards everything
    bus.uart_tx_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      put(3, 8'(8'hC0 + j));
      tick();
    end
    bus.ch_tx_valid = '0;
    check_out("t5_pre", 1'b1, 2'd3, 8'hC0);
    do_reset();
    check_out("t5_rst", 1'b0, 2'd0, 8'h00);
    check("t5_ready", 32'(bus.ch_tx_ready), 32'hF);
    bus.uart_tx_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      check_out($sformatf("t5_quiet%0d", j), 1'b0, 2'd0, 8'h00);
    end
    put(0, 8'h5A);
    tick();
    bus.ch_tx_valid = '0;
    tick();
    check_out("t5_first", 1'b1, 2'd0, 8'h5A);
    tick();
    check_out("t5_done", 1'b0, 2'd0, 8'h00);
    // simultaneous push and pop on channel 0 with 4 bytes buffered
    bus.uart_tx_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      put(0, 8'(8'h40 + j));
      tick();
    end
    bus.uart_tx_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      put(0, 8'(8'h45 + j));
      check($sformatf("t6_rdy%0d", j), 32'(bus.ch_tx_ready[0]), 1);
      check_out($sformatf("t6_o%0d", j), 1'b1, 2'd0, 8'(8'h40 + j));
      tick();
    end
    bus.ch_tx_valid = '0;
    for (int j = 10; j < 15; j++) begin
      check_out($sformatf("t6_o%0d", j), 1'b1, 2'd0, 8'(8'h40 + j));
      tick();
    end
    check_out("t6_end", 1'b0, 2'd0, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
